midi_msg_parser: RTL and testbench

- Downstream consumer of the UART MIDI receive stage; takes the per-byte stream (byte strobe plus 8-bit byte) and assembles complete MIDI channel messages.
- Tracks running status, skips SysEx and system-common data, and ignores real-time bytes.
- Emits one decoded event per complete channel-voice message to the voice allocator: type, channel, two 7-bit data fields.

---
 rtl/midi_msg_parser_pkg.sv | 38 +++
 rtl/midi_status_decode.sv | 42 ++++
 rtl/midi_msg_parser.sv | 136 +++++++++++++
 tb/tb_midi_msg_parser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_msg_parser_pkg.sv
// Shared types and constants for the MIDI message parser.
package midi_msg_parser_pkg;

   typedef enum logic [2:0] {
      EVT_NOTE_OFF    = 3'd0,
      EVT_NOTE_ON     = 3'd1,
      EVT_CTRL_CHANGE = 3'd2,
      EVT_PITCH_BEND  = 3'd3
   } midi_evt_t;

   typedef enum logic [1:0] {
      CLS_DATA = 2'd0,
      CLS_CHAN = 2'd1,
      CLS_SYS  = 2'd2,
      CLS_RT   = 2'd3
   } byte_cls_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_D1 = 3'd1,
      ST_WAIT_D2 = 3'd2,
      ST_SKIP_N  = 3'd3,
      ST_SYSEX   = 3'd4
   } parse_state_t;

   localparam logic [3:0] STAT_NOTE_OFF = 4'h8;
   localparam logic [3:0] STAT_NOTE_ON  = 4'h9;
   localparam logic [3:0] STAT_POLY_AT  = 4'hA;
   localparam logic [3:0] STAT_CC       = 4'hB;
   localparam logic [3:0] STAT_PROG     = 4'hC;
   localparam logic [3:0] STAT_CHAN_AT  = 4'hD;
   localparam logic [3:0] STAT_BEND     = 4'hE;

   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] RT_MIN      = 8'hF8;

endpackage

// File: rtl/midi_status_decode.sv
// Classifies a MIDI byte; for status bytes also gives data-byte count and event type.
module midi_status_decode
   import midi_msg_parser_pkg::*;
(
   input  logic [7:0] status_in,
   output logic [1:0] cls_out,
   output logic [1:0] data_cnt_out,
   output logic [2:0] evt_type_out,
   output logic       has_evt_out
);

   always_comb begin
      cls_out      = CLS_DATA;
      data_cnt_out = 2'd0;
      evt_type_out = EVT_NOTE_OFF;
      has_evt_out  = 1'b0;
      if (!status_in[7]) begin
         cls_out = CLS_DATA;
      end else if (status_in >= RT_MIN) begin
         cls_out = CLS_RT;
      end else if (status_in[7:4] == 4'hF) begin
         cls_out = CLS_SYS;
         case (status_in[3:0])
            4'h1, 4'h3: data_cnt_out = 2'd1;
            4'h2:       data_cnt_out = 2'd2;
            default:    data_cnt_out = 2'd0;
         endcase
      end else begin
         cls_out = CLS_CHAN;
         case (status_in[7:4])
            STAT_NOTE_OFF: begin data_cnt_out = 2'd2; has_evt_out = 1'b1; evt_type_out = EVT_NOTE_OFF;    end
            STAT_NOTE_ON:  begin data_cnt_out = 2'd2; has_evt_out = 1'b1; evt_type_out = EVT_NOTE_ON;     end
            STAT_CC:       begin data_cnt_out = 2'd2; has_evt_out = 1'b1; evt_type_out = EVT_CTRL_CHANGE; end
            STAT_BEND:     begin data_cnt_out = 2'd2; has_evt_out = 1'b1; evt_type_out = EVT_PITCH_BEND;  end
            STAT_POLY_AT:  data_cnt_out = 2'd2;
            STAT_PROG, STAT_CHAN_AT: data_cnt_out = 2'd1;
            default:       data_cnt_out = 2'd0;
         endcase
      end
   end

endmodule

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel-voice messages (running status, SysEx/system-common skip).
// Define MIDI_CHANNEL_FILTER_EN to emit events only for FILTER_CHANNEL.
module midi_msg_parser
   import midi_msg_parser_pkg::*;
#(
   parameter int unsigned FILTER_CHANNEL = 0
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       byte_valid_in,
   input  logic [7:0] byte_in,
   output logic       evt_valid_out,
   output logic [2:0] evt_type_out,
   output logic [3:0] evt_channel_out,
   output logic [6:0] evt_data1_out,
   output logic [6:0] evt_data2_out,
   output logic [7:0] running_status_out
);

`ifdef MIDI_CHANNEL_FILTER_EN
   localparam logic FILTER_ON = 1'b1;
`else
   localparam logic FILTER_ON = 1'b0;
`endif

   parse_state_t state_q, state_d;
   logic [7:0]   rs_q, rs_d;
   logic [6:0]   d1_q, d1_d;
   logic [1:0]   skip_q, skip_d;
   logic         evt_valid_q, evt_valid_d;
   logic [2:0]   evt_type_q, evt_type_d;
   logic [3:0]   evt_ch_q, evt_ch_d;
   logic [6:0]   evt_d1_q, evt_d1_d;
   logic [6:0]   evt_d2_q, evt_d2_d;

   logic [7:0]   dec_in;
   logic [1:0]   dec_cls, dec_cnt;
   logic [2:0]   dec_type;
   logic         dec_has_evt;
   logic         chan_ok;

   // Status bytes decode themselves; data bytes are interpreted via running status.
   assign dec_in  = byte_in[7] ? byte_in : rs_q;
   assign chan_ok = !FILTER_ON || (rs_q[3:0] == FILTER_CHANNEL[3:0]);

   midi_status_decode u_dec (
      .status_in    (dec_in),
      .cls_out      (dec_cls),
      .data_cnt_out (dec_cnt),
      .evt_type_out (dec_type),
      .has_evt_out  (dec_has_evt)
   );

   always_comb begin
      state_d     = state_q;
      rs_d        = rs_q;
      d1_d        = d1_q;
      skip_d      = skip_q;
      evt_valid_d = 1'b0;
      evt_type_d  = evt_type_q;
      evt_ch_d    = evt_ch_q;
      evt_d1_d    = evt_d1_q;
      evt_d2_d    = evt_d2_q;
      if (byte_valid_in) begin
         if (!byte_in[7]) begin
            case (state_q)
               ST_WAIT_D1: begin
                  d1_d = byte_in[6:0];
                  if (dec_cnt == 2'd2) state_d = ST_WAIT_D2;
               end
               ST_WAIT_D2: begin
                  state_d = ST_WAIT_D1;
                  if (dec_has_evt && chan_ok) begin
                     evt_valid_d = 1'b1;
                     evt_type_d  = (dec_type == EVT_NOTE_ON && byte_in[6:0] == 7'd0) ?
                                   EVT_NOTE_OFF : dec_type;
                     evt_ch_d    = rs_q[3:0];
                     evt_d1_d    = d1_q;
                     evt_d2_d    = byte_in[6:0];
                  end
               end
               ST_SKIP_N: begin
                  skip_d = skip_q - 2'd1;
                  if (skip_q <= 2'd1) state_d = ST_IDLE;
               end
               default: ;
            endcase
         end else if (dec_cls == CLS_CHAN) begin
            rs_d    = byte_in;
            state_d = ST_WAIT_D1;
         end else if (dec_cls == CLS_SYS) begin
            rs_d = 8'h00;
            if (byte_in == SYSEX_START) begin
               state_d = ST_SYSEX;
            end else if (dec_cnt != 2'd0) begin
               state_d = ST_SKIP_N;
               skip_d  = dec_cnt;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= ST_IDLE;
         rs_q        <= 8'h00;
         d1_q        <= 7'd0;
         skip_q      <= 2'd0;
         evt_valid_q <= 1'b0;
         evt_type_q  <= 3'd0;
         evt_ch_q    <= 4'd0;
         evt_d1_q    <= 7'd0;
         evt_d2_q    <= 7'd0;
      end else begin
         state_q     <= state_d;
         rs_q        <= rs_d;
         d1_q        <= d1_d;
         skip_q      <= skip_d;
         evt_valid_q <= evt_valid_d;
         evt_type_q  <= evt_type_d;
         evt_ch_q    <= evt_ch_d;
         evt_d1_q    <= evt_d1_d;
         evt_d2_q    <= evt_d2_d;
      end
   end

   assign evt_valid_out      = evt_valid_q;
   assign evt_type_out       = evt_type_q;
   assign evt_channel_out    = evt_ch_q;
   assign evt_data1_out      = evt_d1_q;
   assign evt_data2_out      = evt_d2_q;
   assign running_status_out = rs_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: message-level reference model plus literal checks.
module tb_midi_msg_parser;
   import midi_msg_parser_pkg::*;

`ifdef MIDI_CHANNEL_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       byte_valid_in = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       evt_valid_out;
   logic [2:0] evt_type_out;
   logic [3:0] evt_channel_out;
   logic [6:0] evt_data1_out, evt_data2_out;
   logic [7:0] running_status_out;

   int vectors = 0;
   int miscompares = 0;
   int dut_evts = 0;

   midi_msg_parser #(.FILTER_CHANNEL(2)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .byte_valid_in      (byte_valid_in),
      .byte_in            (byte_in),
      .evt_valid_out      (evt_valid_out),
      .evt_type_out       (evt_type_out),
      .evt_channel_out    (evt_channel_out),
      .evt_data1_out      (evt_data1_out),
      .evt_data2_out      (evt_data2_out),
      .running_status_out (running_status_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: running status plus a buffer of data bytes collected for it.
   logic [7:0] m_rs;
   logic [6:0] m_buf[$];
   int         m_skip;
   bit         m_sysex;
   logic       m_valid;
   logic [2:0] m_type;
   logic [3:0] m_ch;
   logic [6:0] m_d1, m_d2;

   task automatic emit(input logic [7:0] st, input logic [6:0] a, input logic [6:0] b);
      logic [2:0] t;
      bit         has;
      has = 1'b1;
      t   = EVT_NOTE_OFF;
      case (st[7:4])
         4'h8: t = EVT_NOTE_OFF;
         4'h9: t = (b == 7'd0) ? EVT_NOTE_OFF : EVT_NOTE_ON;
         4'hB: t = EVT_CTRL_CHANGE;
         4'hE: t = EVT_PITCH_BEND;
         default: has = 1'b0;
      endcase
      if (FILT && st[3:0] != 4'd2) has = 1'b0;
      if (has) begin
         m_valid = 1'b1;
         m_type  = t;
         m_ch    = st[3:0];
         m_d1    = a;
         m_d2    = b;
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic [7:0] b);
      int need;
      m_valid = 1'b0;
      if (r) begin
         m_rs = 8'h00; m_buf.delete(); m_skip = 0; m_sysex = 0;
         m_type = 3'd0; m_ch = 4'd0; m_d1 = 7'd0; m_d2 = 7'd0;
      end else if (v && b < 8'hF8) begin
         if (b >= 8'h80 && b <= 8'hEF) begin
            m_rs = b; m_buf.delete(); m_skip = 0; m_sysex = 0;
         end else if (b == 8'hF0) begin
            m_rs = 8'h00; m_buf.delete(); m_skip = 0; m_sysex = 1;
         end else if (b >= 8'hF1) begin
            m_rs = 8'h00; m_buf.delete(); m_sysex = 0;
            m_skip = (b == 8'hF1 || b == 8'hF3) ? 1 : (b == 8'hF2) ? 2 : 0;
         end else if (m_sysex) begin
         end else if (m_skip > 0) begin
            m_skip--;
         end else if (m_rs != 8'h00) begin
            m_buf.push_back(b[6:0]);
            need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
            if (m_buf.size() == need) begin
               if (need == 2) emit(m_rs, m_buf[0], m_buf[1]);
               m_buf.delete();
            end
         end
      end
   endtask

   // Compare process: sample inputs at the edge, check outputs 1 time unit later.
   initial begin
      logic r, v;
      logic [7:0] b;
      forever begin
         @(posedge clk_in);
         r = rst_in; v = byte_valid_in; b = byte_in;
         #1;
         model_step(r, v, b);
         chk("evt_valid", evt_valid_out, m_valid);
         chk("running_status", running_status_out, m_rs);
         chk("evt_type", evt_type_out, m_type);
         chk("evt_channel", evt_channel_out, m_ch);
         chk("evt_data1", evt_data1_out, m_d1);
         chk("evt_data2", evt_data2_out, m_d2);
         if (evt_valid_out === 1'b1) dut_evts++;
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk_in);
      byte_valid_in = 1'b1;
      byte_in       = b;
   endtask

   task automatic idle();
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      byte_in       = 8'h00;
   endtask

   task automatic lit_evt(input string name, input logic [2:0] t, input logic [3:0] ch,
                          input logic [6:0] a, input logic [6:0] b);
      logic pulse;
      pulse = !FILT || ch == 4'd2;
      chk({name, ".valid"}, evt_valid_out, pulse);
      if (pulse) begin
         chk({name, ".type"}, evt_type_out, t);
         chk({name, ".ch"}, evt_channel_out, ch);
         chk({name, ".d1"}, evt_data1_out, a);
         chk({name, ".d2"}, evt_data2_out, b);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      chk("lit.reset_valid", evt_valid_out, 1'b0);
      chk("lit.reset_rs", running_status_out, 8'h00);
      chk("lit.reset_fields", {evt_type_out, evt_channel_out, evt_data1_out, evt_data2_out}, 21'd0);

      // Note on, then note off via running status with velocity 0
      send(8'h90); send(8'h3C); send(8'h64); send(8'h3C);
      lit_evt("lit.note_on", EVT_NOTE_ON, 4'd0, 7'h3C, 7'h64);
      send(8'h00); idle();
      lit_evt("lit.note_off_v0", EVT_NOTE_OFF, 4'd0, 7'h3C, 7'h00);

      // Running status with interleaved real-time bytes
      send(8'h93); send(8'h40); send(8'hF8); send(8'h7F); send(8'h41);
      lit_evt("lit.rs_rt1", EVT_NOTE_ON, 4'd3, 7'h40, 7'h7F);
      send(8'hFE); send(8'h20); idle();
      lit_evt("lit.rs_rt2", EVT_NOTE_ON, 4'd3, 7'h41, 7'h20);

      // SysEx skip
      send(8'hF0); send(8'h01);
      chk("lit.sysex_rs", running_status_out, 8'h00);
      send(8'h02); send(8'h03); send(8'hF7); send(8'h45); idle();
      chk("lit.sysex_noevt", evt_valid_out, 1'b0);

      // SysEx then note
      send(8'hF0); send(8'h01); send(8'h02); send(8'h03); send(8'hF7);
      send(8'h91); send(8'h45); send(8'h10); idle();
      lit_evt("lit.sysex_note", EVT_NOTE_ON, 4'd1, 7'h45, 7'h10);

      // Status interrupts a partial control change
      send(8'hB2); send(8'h07); send(8'hE0); send(8'h00); send(8'h40); idle();
      lit_evt("lit.bend", EVT_PITCH_BEND, 4'd0, 7'h00, 7'h40);

      // One-data types and system common skip
      send(8'hC5); send(8'h0A); send(8'h0B); send(8'hF2); send(8'h12); send(8'h34);
      send(8'h7F); idle();
      chk("lit.syscommon_noevt", evt_valid_out, 1'b0);
      chk("lit.syscommon_rs", running_status_out, 8'h00);

      // Reset mid-message
      send(8'h90); send(8'h3C);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      chk("lit.midreset_fields", {evt_type_out, evt_channel_out, evt_data1_out, evt_data2_out}, 21'd0);
      chk("lit.midreset_rs", running_status_out, 8'h00);
      send(8'h64); idle();
      chk("lit.midreset_noevt", evt_valid_out, 1'b0);

      // Channel filter sequence (all channels pass when filter is compiled out)
      send(8'h91); send(8'h3C); send(8'h64); idle();
      lit_evt("lit.filt_ch1", EVT_NOTE_ON, 4'd1, 7'h3C, 7'h64);
      send(8'h92); send(8'h3C); send(8'h64); idle();
      lit_evt("lit.filt_ch2", EVT_NOTE_ON, 4'd2, 7'h3C, 7'h64);

      repeat (3) idle();
      chk("lit.event_count", dut_evts, FILT ? 32'd1 : 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
